// File: rtl/regfile_2r1w_pkg.sv
// Shared CPU constants: register file geometry and architectural register names.
// Imported by the register file, the decoder and the bench.
package regfile_2r1w_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Architectural register indices (MIPS-style naming).
    localparam int REG_ZERO = 0;
    localparam int REG_AT   = 1;
    localparam int REG_V0   = 2;
    localparam int REG_V1   = 3;
    localparam int REG_A0   = 4;
    localparam int REG_A1   = 5;
    localparam int REG_A2   = 6;
    localparam int REG_A3   = 7;
    localparam int REG_T0   = 8;
    localparam int REG_S0   = 16;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

    function automatic int reg_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_2r1w_rd_mux.sv
// One combinational read port: selects a register by index, forcing index 0 to zero.
// Instantiated once per read port so all three ports behave identically.
module regfile_2r1w_rd_mux
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  idx,
    output logic [DATA_W-1:0]                  data
);

    always_comb begin
        data = '0;
        if (idx != ADDR_W'(REG_ZERO)) begin
            data = regs[idx];
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// 32-entry register file: two combinational read ports, one synchronous write port,
// a non-bypassing debug read port, and optional write-through forwarding.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 0
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [ADDR_W-1:0] Rna,
    input  logic [ADDR_W-1:0] Rnb,
    output logic [DATA_W-1:0] Qa,
    output logic [DATA_W-1:0] Qb,
    input  logic              We,
    input  logic [ADDR_W-1:0] Wn,
    input  logic [DATA_W-1:0] D,
    input  logic [ADDR_W-1:0] Dbgn,
    output logic [DATA_W-1:0] Dbgq
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_d;
    logic [DATA_W-1:0]            rd_a;
    logic [DATA_W-1:0]            rd_b;
    logic                         wr_hit;

    assign wr_hit = We && (Wn != ADDR_W'(REG_ZERO));

    // Entry 0 is pinned to zero so its flops reduce to constants in synthesis.
    always_comb begin
        regs_d    = regs_q;
        regs_d[0] = '0;
        if (wr_hit) begin
            regs_d[Wn] = D;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_2r1w_rd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
        .regs (regs_q),
        .idx  (Rna),
        .data (rd_a)
    );

    regfile_2r1w_rd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
        .regs (regs_q),
        .idx  (Rnb),
        .data (rd_b)
    );

    regfile_2r1w_rd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_dbg (
        .regs (regs_q),
        .idx  (Dbgn),
        .data (Dbgq)
    );

    // Forwarding is only legal in a pipelined core; single-cycle use would loop through the ALU.
    always_comb begin
        Qa = rd_a;
        Qb = rd_b;
        if ((BYPASS != 0) && wr_hit) begin
            if (Rna == Wn) begin
                Qa = D;
            end
            if (Rnb == Wn) begin
                Qb = D;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench: BYPASS=0 and BYPASS=1 instances share stimulus and are
// compared against an array model of the architectural register state.
module tb_regfile_2r1w;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic [4:0]  Rna, Rnb, Wn, Dbgn;
    logic        We;
    logic [31:0] D;
    logic [31:0] qa0, qb0, dbg0;
    logic [31:0] qa1, qb1, dbg1;

    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
        .Clk(Clk), .Clrn(Clrn), .Rna(Rna), .Rnb(Rnb), .Qa(qa0), .Qb(qb0),
        .We(We), .Wn(Wn), .D(D), .Dbgn(Dbgn), .Dbgq(dbg0)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut1 (
        .Clk(Clk), .Clrn(Clrn), .Rna(Rna), .Rnb(Rnb), .Qa(qa1), .Qb(qb1),
        .We(We), .Wn(Wn), .D(D), .Dbgn(Dbgn), .Dbgq(dbg1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // A rising edge commits a write only when out of reset, enabled, and not aimed at r0.
    task automatic tick();
        @(posedge Clk);
        if (Clrn === 1'b1 && We === 1'b1 && Wn != 5'd0) model[Wn] = D;
        @(negedge Clk);
    endtask

    // Expected outputs follow the architectural rules directly from current inputs and model.
    task automatic checkOutput(input string tag);
        logic        wr_live;
        logic [31:0] ea1, eb1;
        #1;
        wr_live = (We === 1'b1) && (Wn != 5'd0);
        ea1 = (wr_live && Rna == Wn) ? D : model[Rna];
        eb1 = (wr_live && Rnb == Wn) ? D : model[Rnb];
        check({tag, ".qa0"},  qa0,  model[Rna]);
        check({tag, ".qb0"},  qb0,  model[Rnb]);
        check({tag, ".dbg0"}, dbg0, model[Dbgn]);
        check({tag, ".qa1"},  qa1,  ea1);
        check({tag, ".qb1"},  qb1,  eb1);
        check({tag, ".dbg1"}, dbg1, model[Dbgn]);
    endtask

    initial begin
        Clrn = 1'b0; We = 1'b0; Wn = '0; D = '0; Rna = '0; Rnb = '0; Dbgn = '0;
        clear_model();

        #2;
        Rna = 5'd7; Rnb = 5'd31; Dbgn = 5'd12;
        checkOutput("reset");
        @(negedge Clk);
        Clrn = 1'b1;

        // Write r5, then pulse reset between edges.
        We = 1'b1; Wn = 5'd5; D = 32'hDEADBEEF; Rna = 5'd5; Rnb = 5'd5; Dbgn = 5'd5;
        tick();
        We = 1'b0;
        checkOutput("wr_r5");
        check("wr_r5.direct", qa0, 32'hDEADBEEF);
        Clrn = 1'b0;
        clear_model();
        checkOutput("async_clr");
        check("async_clr.direct", qa0, 32'h0);
        Clrn = 1'b1;

        // Plain write/read on all ports.
        We = 1'b1; Wn = 5'd8; D = 32'h0000_1234;
        tick();
        We = 1'b0; Rna = 5'd8; Rnb = 5'd8; Dbgn = 5'd8;
        checkOutput("wr_r8");
        check("wr_r8.direct", dbg0, 32'h0000_1234);

        // Writes to r0 are dropped; sweep everything through the debug port.
        We = 1'b1; Wn = 5'd0; D = 32'hFFFF_FFFF; Rna = 5'd0; Rnb = 5'd0;
        tick();
        We = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Dbgn = 5'(i);
            checkOutput("r0_sweep");
        end

        // Read-during-write: old value without bypass, new value with bypass.
        We = 1'b1; Wn = 5'd3; D = 32'h11;
        tick();
        D = 32'h22; Rna = 5'd3; Rnb = 5'd4; Dbgn = 5'd3;
        checkOutput("rdw_pre");
        check("rdw_pre.qa0", qa0, 32'h11);
        check("rdw_pre.qa1", qa1, 32'h22);
        check("rdw_pre.dbg1", dbg1, 32'h11);
        tick();
        checkOutput("rdw_post");
        check("rdw_post.qa0", qa0, 32'h22);
        Wn = 5'd0; D = 32'h33; Rna = 5'd0;
        checkOutput("rdw_r0");
        check("rdw_r0.qa1", qa1, 32'h0);
        tick();

        // Write enable gating and reset dominating a write.
        We = 1'b0; Wn = 5'd9; D = 32'hAA; Dbgn = 5'd9;
        tick();
        checkOutput("we_gate");
        Clrn = 1'b0;
        clear_model();
        We = 1'b1; D = 32'h55;
        tick();
        We = 1'b0;
        Clrn = 1'b1;
        checkOutput("rst_prio");
        check("rst_prio.dbg0", dbg0, 32'h0);

        // Randomized traffic with frequent read/write index collisions.
        for (int n = 0; n < 300; n++) begin
            We   = ($urandom_range(0, 3) != 0);
            Wn   = 5'($urandom_range(0, 31));
            D    = $urandom;
            Rna  = ($urandom_range(0, 3) == 0) ? Wn : 5'($urandom_range(0, 31));
            Rnb  = ($urandom_range(0, 3) == 0) ? Wn : 5'($urandom_range(0, 31));
            Dbgn = ($urandom_range(0, 3) == 0) ? Wn : 5'($urandom_range(0, 31));
            checkOutput("rand");
            tick();
        end
        We = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Dbgn = 5'(i);
            Rna  = 5'(i);
            Rnb  = 5'(31 - i);
            checkOutput("final_sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
